// File: rtl/dcache_resp_pkg.sv
// Shared constants for the data-cache request responder: FSM state
// encoding and the default address/data widths.
package dcache_resp_pkg;

    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] ISSUE    = 2'b01;
    localparam logic [1:0] WAIT_RSP = 2'b10;
    localparam logic [1:0] DRAIN    = 2'b11;

    localparam int AW_DEF = 40;
    localparam int DW_DEF = 64;

endpackage

// File: rtl/dcache_req_reg.sv
// Holds the payload of the single outstanding request. Loaded only when a
// new request is accepted so the backend sees a stable payload while the
// initiator is free to change its inputs.
module dcache_req_reg
    import dcache_resp_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            is_store_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] be_i,
    output logic            is_store_o,
    output logic [AW-1:0]   addr_o,
    output logic [DW-1:0]   wdata_o,
    output logic [DW/8-1:0] be_o
);

    logic            is_store_q, is_store_d;
    logic [AW-1:0]   addr_q,     addr_d;
    logic [DW-1:0]   wdata_q,    wdata_d;
    logic [DW/8-1:0] be_q,       be_d;

    // Capture the incoming payload on load, otherwise hold.
    always_comb begin
        is_store_d = is_store_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        if (load_i) begin
            is_store_d = is_store_i;
            addr_d     = addr_i;
            wdata_d    = wdata_i;
            be_d       = be_i;
        end
    end

    // Payload register, cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            is_store_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            is_store_q <= is_store_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
        end
    end

    assign is_store_o = is_store_q;
    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;
    assign be_o       = be_q;

endmodule

// File: rtl/dcache_req_responder.sv
// Data-cache responder: takes one load/store from the initiator, forwards
// it to the memory backend over valid/ready, and returns grant/response
// pulses. Handles squash at every stage; at most one request in flight.
module dcache_req_responder
    import dcache_resp_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    input  logic            req_is_store_i,
    input  logic [AW-1:0]   req_addr_i,
    input  logic [DW-1:0]   req_wdata_i,
    input  logic [DW/8-1:0] req_be_i,
    input  logic            kill_i,
    output logic            ld_gnt_o,
    output logic            st_gnt_o,
    output logic            ld_resp_valid_o,
    output logic [DW-1:0]   ld_resp_data_o,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic            mem_req_we_o,
    output logic [AW-1:0]   mem_req_addr_o,
    output logic [DW-1:0]   mem_req_wdata_o,
    output logic [DW/8-1:0] mem_req_be_o,
    input  logic            mem_resp_valid_i,
    input  logic [DW-1:0]   mem_resp_data_i,
    output logic            busy_o
);

    logic [1:0]    state_q, state_d;
    logic          req_valid_q;
    logic          ld_gnt_q, ld_gnt_d;
    logic          st_gnt_q, st_gnt_d;
    logic          ld_resp_valid_q, ld_resp_valid_d;
    logic [DW-1:0] ld_resp_data_q, ld_resp_data_d;
    logic          mem_req_valid_q, mem_req_valid_d;
    logic          busy_q, busy_d;

    logic          req_rise;
    logic          capture;
    logic          handshake;
    logic          cur_is_store;

    // Only a rising edge starts a request, so a level held past completion
    // is never recaptured.
    assign req_rise  = req_valid_i & ~req_valid_q;
    assign capture   = (state_q == IDLE) & req_rise & ~kill_i;
    assign handshake = (state_q == ISSUE) & mem_req_ready_i;

    dcache_req_reg #(
        .AW(AW),
        .DW(DW)
    ) u_req_reg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (capture),
        .is_store_i (req_is_store_i),
        .addr_i     (req_addr_i),
        .wdata_i    (req_wdata_i),
        .be_i       (req_be_i),
        .is_store_o (cur_is_store),
        .addr_o     (mem_req_addr_o),
        .wdata_o    (mem_req_wdata_o),
        .be_o       (mem_req_be_o)
    );

    // State register plus request-valid edge history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_i;
        end
    end

    // Next-state: a kill racing a handshake still has a response coming,
    // so it must drain; a kill racing the response just drops it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (capture) state_d = ISSUE;
            end
            ISSUE: begin
                if (handshake)   state_d = kill_i ? DRAIN : WAIT_RSP;
                else if (kill_i) state_d = IDLE;
            end
            WAIT_RSP: begin
                if (mem_resp_valid_i) state_d = IDLE;
                else if (kill_i)      state_d = DRAIN;
            end
            DRAIN: begin
                if (mem_resp_valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: every output is the registered image of these values.
    always_comb begin
        ld_gnt_d        = handshake & ~kill_i & ~cur_is_store;
        st_gnt_d        = (state_q == WAIT_RSP) & mem_resp_valid_i & ~kill_i & cur_is_store;
        ld_resp_valid_d = (state_q == WAIT_RSP) & mem_resp_valid_i & ~kill_i & ~cur_is_store;
        ld_resp_data_d  = ld_resp_valid_d ? mem_resp_data_i : ld_resp_data_q;
        mem_req_valid_d = (state_d == ISSUE);
        busy_d          = (state_d != IDLE);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_gnt_q        <= 1'b0;
            st_gnt_q        <= 1'b0;
            ld_resp_valid_q <= 1'b0;
            ld_resp_data_q  <= '0;
            mem_req_valid_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            ld_gnt_q        <= ld_gnt_d;
            st_gnt_q        <= st_gnt_d;
            ld_resp_valid_q <= ld_resp_valid_d;
            ld_resp_data_q  <= ld_resp_data_d;
            mem_req_valid_q <= mem_req_valid_d;
            busy_q          <= busy_d;
        end
    end

    assign ld_gnt_o        = ld_gnt_q;
    assign st_gnt_o        = st_gnt_q;
    assign ld_resp_valid_o = ld_resp_valid_q;
    assign ld_resp_data_o  = ld_resp_data_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_req_we_o    = cur_is_store;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_dcache_req_responder.sv
// Bench for dcache_req_responder: expected backend requests and pulses are
// queued as stimulus is driven and matched in order as the DUT emits them.
module tb_dcache_req_responder;

    localparam int AW = 40;
    localparam int DW = 64;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_i, req_is_store_i, kill_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic [BW-1:0] req_be_i;
    logic          ld_gnt_o, st_gnt_o, ld_resp_valid_o;
    logic [DW-1:0] ld_resp_data_o;
    logic          mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
    logic [AW-1:0] mem_req_addr_o;
    logic [DW-1:0] mem_req_wdata_o;
    logic [BW-1:0] mem_req_be_o;
    logic          mem_resp_valid_i;
    logic [DW-1:0] mem_resp_data_i;
    logic          busy_o;

    int errors = 0;
    int checks = 0;
    logic [127:0] exp_q [$];

    dcache_req_responder #(.AW(AW), .DW(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid_i),
        .req_is_store_i   (req_is_store_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .req_be_i         (req_be_i),
        .kill_i           (kill_i),
        .ld_gnt_o         (ld_gnt_o),
        .st_gnt_o         (st_gnt_o),
        .ld_resp_valid_o  (ld_resp_valid_o),
        .ld_resp_data_o   (ld_resp_data_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_we_o     (mem_req_we_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_wdata_o  (mem_req_wdata_o),
        .mem_req_be_o     (mem_req_be_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Event encodings: kind in the top nibble, payload below.
    function automatic logic [127:0] ev_memreq(logic we, logic [AW-1:0] a, logic [DW-1:0] d, logic [BW-1:0] b);
        return {4'd1, 11'd0, we, a, d, b};
    endfunction
    function automatic logic [127:0] ev_ldgnt();
        return {4'd2, 124'd0};
    endfunction
    function automatic logic [127:0] ev_stgnt();
        return {4'd3, 124'd0};
    endfunction
    function automatic logic [127:0] ev_ldresp(logic [DW-1:0] d);
        return {4'd4, 60'd0, d};
    endfunction

    task automatic sb_match(input string tag, input logic [127:0] ev);
        logic [127:0] e;
        if (exp_q.size() == 0) begin
            chk({"spurious_", tag}, ev, 128'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, ev, e);
        end
    endtask

    // Monitor: sample outputs mid-cycle; a handshake is valid&ready held
    // into the coming edge.
    always @(negedge clk) begin
        if (ld_gnt_o)        sb_match("ld_gnt", ev_ldgnt());
        if (st_gnt_o)        sb_match("st_gnt", ev_stgnt());
        if (ld_resp_valid_o) sb_match("ld_resp", ev_ldresp(ld_resp_data_o));
        if (mem_req_valid_o && mem_req_ready_i)
            sb_match("mem_req", ev_memreq(mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_be_o));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic st, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
        req_valid_i    = 1'b1;
        req_is_store_i = st;
        req_addr_i     = a;
        req_wdata_i    = d;
        req_be_i       = b;
    endtask

    task automatic respond(input logic [DW-1:0] d);
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = d;
        step(1);
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
    endtask

    task automatic drop_req();
        req_valid_i = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b0;
        req_valid_i = 1'b0; req_is_store_i = 1'b0; kill_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0; req_be_i = '0;
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
        step(3);
        chk("rst_busy", busy_o, 0);
        chk("rst_mem_valid", mem_req_valid_o, 0);
        chk("rst_pulses", {ld_gnt_o, st_gnt_o, ld_resp_valid_o}, 0);
        chk("rst_ld_data", ld_resp_data_o, 0);
        chk("rst_addr", mem_req_addr_o, 0);
        rst = 1'b1;
        step(1);

        // Load: ready after 2 cycles, response 3 cycles after grant.
        set_req(1'b0, 40'h80001000, '0, '0);
        exp_q.push_back(ev_memreq(1'b0, 40'h80001000, '0, '0));
        exp_q.push_back(ev_ldgnt());
        exp_q.push_back(ev_ldresp(64'hDEADBEEFCAFEF00D));
        step(1);
        chk("ld_mem_valid", mem_req_valid_o, 1);
        chk("ld_busy", busy_o, 1);
        step(2);
        mem_req_ready_i = 1'b1;
        step(1);
        mem_req_ready_i = 1'b0;
        step(2);
        respond(64'hDEADBEEFCAFEF00D);
        step(1);
        chk("ld_data_held", ld_resp_data_o, 64'hDEADBEEFCAFEF00D);
        chk("ld_done_busy", busy_o, 0);

        // Level held high after completion: nothing new may be issued.
        step(10);
        chk("hold_sb_empty", exp_q.size(), 0);
        chk("hold_mem_valid", mem_req_valid_o, 0);
        drop_req();

        // Store: ready immediately, ack after 4 cycles; inputs scrambled after capture.
        set_req(1'b1, 40'h80002008, 64'h1122334455667788, 8'hF0);
        mem_req_ready_i = 1'b1;
        exp_q.push_back(ev_memreq(1'b1, 40'h80002008, 64'h1122334455667788, 8'hF0));
        exp_q.push_back(ev_stgnt());
        step(1);
        req_addr_i = 40'h0; req_wdata_i = 64'hFFFF; req_be_i = 8'h01; req_is_store_i = 1'b0;
        step(1);
        mem_req_ready_i = 1'b0;
        step(3);
        respond('0);
        step(1);
        chk("st_done_busy", busy_o, 0);
        chk("st_ld_data_kept", ld_resp_data_o, 64'hDEADBEEFCAFEF00D);
        drop_req();

        // Kill during ISSUE without handshake.
        set_req(1'b0, 40'h80003000, '0, '0);
        step(1);
        chk("kissue_valid_pre", mem_req_valid_o, 1);
        kill_i = 1'b1;
        step(1);
        kill_i = 1'b0;
        chk("kissue_valid_post", mem_req_valid_o, 0);
        chk("kissue_busy", busy_o, 0);
        mem_req_ready_i = 1'b1;
        step(3);
        mem_req_ready_i = 1'b0;
        drop_req();

        // Rising edge with kill is ignored.
        set_req(1'b0, 40'h80003100, '0, '0);
        kill_i = 1'b1;
        step(1);
        kill_i = 1'b0;
        step(2);
        chk("kedge_busy", busy_o, 0);
        drop_req();

        // Kill in WAIT_RSP: drain until the response, no load response.
        set_req(1'b0, 40'h80004000, '0, '0);
        mem_req_ready_i = 1'b1;
        exp_q.push_back(ev_memreq(1'b0, 40'h80004000, '0, '0));
        exp_q.push_back(ev_ldgnt());
        step(2);
        mem_req_ready_i = 1'b0;
        kill_i = 1'b1;
        step(1);
        kill_i = 1'b0;
        chk("kwait_busy0", busy_o, 1);
        step(3);
        chk("kwait_busy1", busy_o, 1);
        respond(64'h0BADF00D0BADF00D);
        chk("kwait_busy_end", busy_o, 0);
        chk("kwait_data_kept", ld_resp_data_o, 64'hDEADBEEFCAFEF00D);
        drop_req();

        // Kill coinciding with handshake: drain, no grant.
        set_req(1'b0, 40'h80005000, '0, '0);
        exp_q.push_back(ev_memreq(1'b0, 40'h80005000, '0, '0));
        step(1);
        mem_req_ready_i = 1'b1; kill_i = 1'b1;
        step(1);
        mem_req_ready_i = 1'b0; kill_i = 1'b0;
        chk("khs_busy", busy_o, 1);
        step(2);
        respond(64'h1);
        chk("khs_busy_end", busy_o, 0);
        drop_req();

        // Kill coinciding with the response: suppressed, straight to IDLE.
        set_req(1'b0, 40'h80006000, '0, '0);
        mem_req_ready_i = 1'b1;
        exp_q.push_back(ev_memreq(1'b0, 40'h80006000, '0, '0));
        exp_q.push_back(ev_ldgnt());
        step(2);
        mem_req_ready_i = 1'b0;
        kill_i = 1'b1;
        respond(64'h2);
        kill_i = 1'b0;
        chk("kresp_busy", busy_o, 0);
        step(1);
        drop_req();

        // Zero-wait response right after the handshake.
        set_req(1'b0, 40'h80007000, '0, '0);
        mem_req_ready_i = 1'b1;
        exp_q.push_back(ev_memreq(1'b0, 40'h80007000, '0, '0));
        exp_q.push_back(ev_ldgnt());
        exp_q.push_back(ev_ldresp(64'hA5A5A5A55A5A5A5A));
        step(2);
        mem_req_ready_i = 1'b0;
        respond(64'hA5A5A5A55A5A5A5A);
        step(1);
        chk("zw_data", ld_resp_data_o, 64'hA5A5A5A55A5A5A5A);
        drop_req();

        // Reset while in WAIT_RSP, then a late backend response.
        set_req(1'b0, 40'h80008000, '0, '0);
        mem_req_ready_i = 1'b1;
        exp_q.push_back(ev_memreq(1'b0, 40'h80008000, '0, '0));
        exp_q.push_back(ev_ldgnt());
        step(2);
        mem_req_ready_i = 1'b0;
        rst = 1'b0;
        req_valid_i = 1'b0;
        step(2);
        rst = 1'b1;
        respond(64'h3);
        step(1);
        chk("rmid_busy", busy_o, 0);
        chk("rmid_valid", mem_req_valid_o, 0);
        chk("rmid_pulses", {ld_gnt_o, st_gnt_o, ld_resp_valid_o}, 0);
        chk("rmid_ld_data", ld_resp_data_o, 0);

        // Fresh load after reset completes normally.
        set_req(1'b0, 40'h80009000, '0, '0);
        exp_q.push_back(ev_memreq(1'b0, 40'h80009000, '0, '0));
        exp_q.push_back(ev_ldgnt());
        exp_q.push_back(ev_ldresp(64'h0123456789ABCDEF));
        step(1);
        mem_req_ready_i = 1'b1;
        step(1);
        mem_req_ready_i = 1'b0;
        step(1);
        respond(64'h0123456789ABCDEF);
        step(1);
        chk("post_rst_data", ld_resp_data_o, 64'h0123456789ABCDEF);
        drop_req();

        step(3);
        chk("final_sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_req_responder.md
Name: dcache_req_responder

Overview:
Data-cache-side responder for the core's load/store request interface. It accepts one load or store request from the tile's load/store initiator FSM and forwards it to the memory backend over a valid/ready port. It returns a grant pulse to the initiator and, for loads, a response with data; for stores, a completion grant. It handles kill (squash) at any point and keeps at most one request outstanding.

Parameters:
AW, 40, request address width
DW, 64, data width (bytes = DW/8)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
req_valid_i  in  1  request valid from initiator (level, may stay high past completion)
req_is_store_i  in  1  1 = store, 0 = load; sampled with req_valid_i
req_addr_i  in  AW  physical address (post-translation)
req_wdata_i  in  DW  store data
req_be_i  in  DW/8  store byte enables
kill_i  in  1  squash current operation
ld_gnt_o  out  1  pulse: load accepted by backend
st_gnt_o  out  1  pulse: store completed (backend write-ack)
ld_resp_valid_o  out  1  pulse: load data valid
ld_resp_data_o  out  DW  load data, held until next load response
mem_req_valid_o  out  1  backend request valid
mem_req_ready_i  in  1  backend accepts request
mem_req_we_o  out  1  backend write enable
mem_req_addr_o  out  AW  backend address
mem_req_wdata_o  out  DW  backend write data
mem_req_be_o  out  DW/8  backend byte enables
mem_resp_valid_i  in  1  backend response (load data or store ack)
mem_resp_data_i  in  DW  backend load data
busy_o  out  1  state != IDLE

Behaviour:
- All outputs registered. Reset (rst=0 at a clk edge): state=IDLE. All pulses, mem_req_valid_o and busy_o are 0. ld_resp_data_o=0. The request register is 0. req_valid_q=0. Reset mid-operation abandons the request with no pulses; a later backend response is ignored in IDLE.
- req_valid_q registers req_valid_i every cycle. A new request is a rising edge (req_valid_i & ~req_valid_q). This prevents a level held past completion from being recaptured.
- IDLE: on rising edge with kill_i=0, latch is_store/addr/wdata/be and go to ISSUE. mem_req_valid_o=1 from the next cycle, so request-to-backend latency is 1 cycle. A rising edge with kill_i=1 is ignored.
- ISSUE: mem_req_valid_o and the payload are held stable until mem_req_ready_i.
  - Handshake in a cycle with kill_i=0 -> WAIT_RSP. ld_gnt_o pulses the next cycle if load; no pulse for store.
  - kill_i=1 without handshake -> IDLE, mem_req_valid_o drops next cycle, no pulses.
  - kill_i=1 in the same cycle as the handshake -> request is already sent, go to DRAIN, no ld_gnt_o.
- WAIT_RSP, on mem_resp_valid_i with kill_i=0:
  - Load: ld_resp_valid_o=1 and ld_resp_data_o=mem_resp_data_i next cycle.
  - Store: st_gnt_o=1 next cycle.
  - State -> IDLE.
  - kill_i=1 with no response -> DRAIN.
  - kill_i=1 with a response in the same cycle -> response suppressed, state -> IDLE.
- DRAIN: wait for mem_resp_valid_i, discard it, no pulses, -> IDLE. kill_i has no further effect.
- Pulses are exactly 1 cycle. ld_gnt_o and ld_resp_valid_o can never coincide because a response needs at least 1 cycle after the handshake. A backend response with zero wait after the handshake cycle is legal.
- mem_resp_valid_i in IDLE or ISSUE is spurious: ignored, no state change.

Decomposition:
- Shared package dcache_resp_pkg: state encoding localparams (IDLE=2'b00, ISSUE=2'b01, WAIT_RSP=2'b10, DRAIN=2'b11) and default AW/DW constants.
- Optional sub-module dcache_req_reg: the latch for the request payload, cleared on reset.
- FSM and pulse generation stay in the top module.

Test Plan:
- Load at addr 0x80001000, ready 2 cycles after valid, response data 0xDEADBEEFCAFEF00D 3 cycles later -> one ld_gnt_o pulse, then one ld_resp_valid_o pulse with that data; mem_req_we_o=0.
- Store with wdata 0x1122334455667788, be=0xF0, ready immediate, ack after 4 cycles -> mem_req_we_o=1 with payload intact; st_gnt_o pulses once; no ld_* pulses.
- req_valid_i held high for 10 cycles after completion -> exactly one backend request is issued; the next request fires only after req_valid_i drops and rises again.
- kill_i during ISSUE with mem_req_ready_i=0 -> mem_req_valid_o falls next cycle; no pulses; busy_o=0.
- kill_i in WAIT_RSP for a load, response 5 cycles later -> DRAIN; no ld_resp_valid_o; busy_o stays 1 until the response, then 0.
- rst=0 while in WAIT_RSP, then the backend responds -> all outputs 0, no pulses; a new load then completes normally.
